// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode/issue front end: opcodes, FSM
// state encoding and instruction-register field layout.
package cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 5;
  localparam int DST_HI = 4;
  localparam int DST_LO = 3;
  localparam int SRC_HI = 2;
  localparam int SRC_LO = 0;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] dest;
    logic [2:0] src;
  } instr_t;

  function automatic instr_t decode_instr(input logic [7:0] word);
    instr_t f;
    f.opcode = word[OPC_HI:OPC_LO];
    f.dest   = word[DST_HI:DST_LO];
    f.src    = word[SRC_HI:SRC_LO];
    return f;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter with synchronous clear-to-zero, increment, and a flag marking
// the last addressable word so the caller can stop instead of wrapping.
module program_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              at_end
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // NOTE: pc_d gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (inc && !at_end) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign at_end = (pc_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch/decode/issue sequencer: walks a combinational instruction
// memory from address 0, offering each decoded word to the datapath until HALT.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter int         ADDR_W  = 4,
  parameter int         INSTR_W = 8,
  parameter logic [2:0] HALT_OP = OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [2:0]         issue_opcode,
  output logic [1:0]         issue_dest,
  output logic [2:0]         issue_src,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic [ADDR_W:0]    retired
);

  localparam logic [ADDR_W:0] RETIRED_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W:0]    retired_q, retired_d;
  logic               run_start, accept, pc_at_end;
  instr_t             ir_fields;

  assign ir_fields = decode_instr(ir_q[7:0]);

  // abort outranks both start and the issue handshake.
  assign run_start = start && !abort && (state_q == ST_IDLE || state_q == ST_HALT);
  assign accept    = (state_q == ST_ISSUE) && issue_ready && !abort;

  program_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (run_start),
    .inc    (accept),
    .pc     (pc),
    .at_end (pc_at_end)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_d   = ST_FETCH;
            retired_d = '0;
          end
        end
        ST_FETCH: begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end
        ST_DECODE: begin
          state_d = (ir_fields.opcode == HALT_OP) ? ST_HALT : ST_ISSUE;
        end
        ST_ISSUE: begin
          if (issue_ready) begin
            if (retired_q != RETIRED_MAX) retired_d = retired_q + 1'b1;
            // The last word of memory ends the run rather than wrapping to 0.
            state_d = pc_at_end ? ST_HALT : ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr    = pc;
  assign issue_valid  = (state_q == ST_ISSUE);
  assign issue_opcode = ir_fields.opcode;
  assign issue_dest   = ir_fields.dest;
  assign issue_src    = ir_fields.src;
  assign busy         = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_ISSUE);
  assign halted       = (state_q == ST_HALT);
  assign retired      = retired_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller; inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_fetch_controller;
  import cpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic       issue_valid;
  logic       issue_ready;
  logic [2:0] issue_opcode;
  logic [1:0] issue_dest;
  logic [2:0] issue_src;
  logic [3:0] pc;
  logic       busy;
  logic       halted;
  logic [4:0] retired;

  logic [7:0] mem [16];
  int         errors = 0;
  int         checks = 0;

  assign imem_data = mem[imem_addr];

  fetch_controller #(.ADDR_W(4), .INSTR_W(8), .HALT_OP(3'b111)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_opcode (issue_opcode),
    .issue_dest   (issue_dest),
    .issue_src    (issue_src),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle(input string tag, input logic [3:0] exp_pc, input logic [4:0] exp_ret);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_valid"}, issue_valid, 1'b0);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_retired"}, retired, exp_ret);
  endtask

  task automatic check_issue(input string tag, input logic [2:0] op, input logic [1:0] dst,
                             input logic [2:0] src);
    check({tag, "_valid"}, issue_valid, 1'b1);
    check({tag, "_opcode"}, issue_opcode, op);
    check({tag, "_dest"}, issue_dest, dst);
    check({tag, "_src"}, issue_src, src);
  endtask

  task automatic check_halt(input string tag, input logic [3:0] exp_pc, input logic [4:0] exp_ret);
    check({tag, "_halted"}, halted, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, issue_valid, 1'b0);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_retired"}, retired, exp_ret);
  endtask

  task automatic load_program();
    for (int i = 0; i < 16; i++) mem[i] = 8'hE0;
    mem[0] = 8'hAD;
    mem[1] = 8'hB6;
    mem[2] = 8'h1A;
    mem[3] = 8'hE0;
  endtask

  // Start pulse on one falling edge, cleared on the next; returns in FETCH.
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    issue_ready = 1'b0;
    load_program();

    // Reset state, and release of reset alone does not start a run.
    step(2);
    check_idle("reset", 4'd0, 5'd0);
    rst_n = 1'b1;
    step(3);
    check_idle("post_reset", 4'd0, 5'd0);

    // Basic program with ready always high: issues 3 cycles apart.
    issue_ready = 1'b1;
    pulse_start();
    check("run1_fetch_busy", busy, 1'b1);
    check("run1_fetch_valid", issue_valid, 1'b0);
    step(1);
    check("run1_decode_valid", issue_valid, 1'b0);
    step(1);
    check_issue("run1_i0", OP_MOV, 2'b01, 3'b101);
    check("run1_i0_pc", pc, 4'd0);
    step(3);
    check_issue("run1_i1", OP_MOV, 2'b10, 3'b110);
    check("run1_i1_pc", pc, 4'd1);
    check("run1_i1_retired", retired, 5'd1);
    step(3);
    check_issue("run1_i2", OP_ADD, 2'b11, 3'b010);
    step(3);
    check_halt("run1_end", 4'd3, 5'd3);

    // Backpressure: ready low for the first 4 cycles of the first issue.
    issue_ready = 1'b0;
    pulse_start();
    check("run2_restart_retired", retired, 5'd0);
    check("run2_restart_pc", pc, 4'd0);
    step(2);
    for (int i = 0; i < 4; i++) begin
      check_issue($sformatf("run2_hold%0d", i), OP_MOV, 2'b01, 3'b101);
      check($sformatf("run2_hold%0d_retired", i), retired, 5'd0);
      if (i == 3) issue_ready = 1'b1;
      step(1);
    end
    check("run2_after_accept_pc", pc, 4'd1);
    check("run2_after_accept_valid", issue_valid, 1'b0);
    step(8);
    check_halt("run2_end", 4'd3, 5'd3);

    // Abort coinciding with an accepted handshake voids that handshake.
    pulse_start();
    step(2);
    check_issue("run3_i0", OP_MOV, 2'b01, 3'b101);
    step(3);
    check_issue("run3_i1", OP_MOV, 2'b10, 3'b110);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_idle("run3_abort", 4'd1, 5'd1);
    pulse_start();
    check("run3_restart_pc", pc, 4'd0);
    check("run3_restart_retired", retired, 5'd0);
    check("run3_restart_busy", busy, 1'b1);
    step(2);
    check_issue("run3_restart_i0", OP_MOV, 2'b01, 3'b101);
    step(9);
    check_halt("run3_end", 4'd3, 5'd3);

    // Sixteen non-HALT words: stop at the top address without wrapping.
    for (int i = 0; i < 16; i++) mem[i] = 8'h1A;
    pulse_start();
    step(2);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("run4_i%0d_valid", i), issue_valid, 1'b1);
      check($sformatf("run4_i%0d_pc", i), pc, i[3:0]);
      check($sformatf("run4_i%0d_retired", i), retired, i[4:0]);
      if (i < 15) step(3);
    end
    step(1);
    check_halt("run4_end", 4'd15, 5'd16);
    step(3);
    check_halt("run4_stay", 4'd15, 5'd16);

    // Start while busy is ignored; async reset mid-DECODE acts before the next edge.
    load_program();
    pulse_start();
    step(2);
    check_issue("run5_i0", OP_MOV, 2'b01, 3'b101);
    start = 1'b1;
    step(1);
    check("run5_fetch_pc", pc, 4'd1);
    check("run5_fetch_retired", retired, 5'd1);
    step(1);
    start = 1'b0;
    check("run5_decode_pc", pc, 4'd1);
    check("run5_decode_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("run5_async_reset", 4'd0, 5'd0);
    step(1);
    rst_n = 1'b1;
    step(2);
    check_idle("run5_after_release", 4'd0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
